hazard_ctrl: RTL and testbench

//  Interlock controller for the bexkat1 decode stage. Tracks in-flight register writes

---
 rtl/hazard_ctrl_pkg.sv | 65 ++++++
 rtl/hazard_ctrl_scoreboard_entry.sv | 50 +++++
 rtl/hazard_ctrl.sv | 99 +++++++++
 tb/tb_hazard_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// bexkat1Def: instruction type codes plus register-usage decode helpers
// shared by the decode-stage interlock logic.
package bexkat1Def;

  typedef enum logic [3:0] {
    T_INH    = 4'h0,
    T_PUSH   = 4'h1,
    T_POP    = 4'h2,
    T_CMP    = 4'h3,
    T_MOV    = 4'h4,
    T_INTU   = 4'h5,
    T_ALU    = 4'h6,
    T_INT    = 4'h7,
    T_LDI    = 4'h8,
    T_LOAD   = 4'h9,
    T_STORE  = 4'ha,
    T_BRANCH = 4'hb,
    T_JUMP   = 4'hc
  } insn_type_t;

  typedef struct packed {
    logic       use_a;
    logic [3:0] addr_a;
    logic       use_b;
    logic [3:0] addr_b;
  } src_t;

  typedef struct packed {
    logic       writes;
    logic [3:0] addr;
  } dst_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] dst;
    logic       fwdable;
  } ex_track_t;

  // Slot a feeds read1, slot b feeds read2.
  function automatic src_t src_regs(input logic [31:0] ir);
    src_t s;
    case (ir[31:28])
      T_LDI:                 s = '0;
      T_CMP, T_STORE, T_LOAD: s = {1'b1, ir[23:20], 1'b1, ir[19:16]};
      default:               s = {1'b1, ir[19:16], 1'b1, ir[15:12]};
    endcase
    return s;
  endfunction

  function automatic dst_t dst_reg(input logic [31:0] ir);
    dst_t d;
    d.addr = ir[23:20];
    case (ir[31:28])
      T_LDI, T_LOAD, T_ALU: d.writes = 1'b1;
      T_MOV:                d.writes = |ir[25:24];
      default:              d.writes = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic is_alu_or_mov(input logic [31:0] ir);
    return (ir[31:28] == T_ALU) || (ir[31:28] == T_MOV);
  endfunction

endpackage

// File: rtl/hazard_ctrl_scoreboard_entry.sv
// scoreboard_entry: outstanding-write count for one register.
// Latency: count updates at the edge; busy/full are registered state. No backpressure.
// Net change per edge is +inc -dec_wb -dec_sq; the count never goes below 0 or above MAX_INFLIGHT.
module scoreboard_entry #(
  parameter int MAX_INFLIGHT = 3,
  parameter int CW           = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          inc_i,
  input  logic          dec_wb_i,
  input  logic          dec_sq_i,
  output logic          busy_o,
  output logic          full_o,
  output logic [CW-1:0] count_o
);

  logic [CW-1:0]        count_q;
  logic [CW-1:0]        count_d;
  logic signed [CW+1:0] nxt_s;
  logic                 underflow;

  assign nxt_s = $signed({2'b00, count_q})
               + $signed({{(CW+1){1'b0}}, inc_i})
               - $signed({{(CW+1){1'b0}}, dec_wb_i})
               - $signed({{(CW+1){1'b0}}, dec_sq_i});

  assign underflow = nxt_s[CW+1];

  always_comb begin
    count_d = nxt_s[CW-1:0];
    if (underflow)
      count_d = '0;
    else if (nxt_s > $signed((CW+2)'(MAX_INFLIGHT)))
      count_d = CW'(MAX_INFLIGHT);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign busy_o  = (count_q != '0);
  assign full_o  = (count_q == CW'(MAX_INFLIGHT));
  assign count_o = count_q;

  // Retiring or squashing a write that was never tracked is a protocol error.
  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i) !underflow);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: bexkat1 decode interlock; per-register write scoreboard stalls decode on pending sources.
// Latency: zero-cycle combinational issue/stall decision; scoreboard updates at the edge.
// Backpressure: stall_o/bubble_o when a source is pending, the destination is full, or ex_ready_i=0.
// Optional EX forwarding is built when BEXKAT1_FORWARD_EN is defined.
module hazard_ctrl
  import bexkat1Def::*;
#(
  parameter int MAX_INFLIGHT = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        dec_valid_i,
  input  logic [31:0] dec_ir_i,
  input  logic        ex_ready_i,
  input  logic        wb_en_i,
  input  logic [3:0]  wb_addr_i,
  input  logic        squash_en_i,
  input  logic [3:0]  squash_addr_i,
  output logic        issue_o,
  output logic        stall_o,
  output logic        bubble_o,
  output logic        fwd_a_o,
  output logic        fwd_b_o,
  output logic [31:0] stall_cnt_o
);

  localparam int CW = $clog2(MAX_INFLIGHT + 1);

`ifdef BEXKAT1_FORWARD_EN
  localparam logic FWD_EN = 1'b1;
`else
  localparam logic FWD_EN = 1'b0;
`endif

  src_t      src;
  dst_t      dst;
  ex_track_t ex_q;

  logic [15:0]   inc, dec_wb, dec_sq, busy, full;
  logic [CW-1:0] cnt [16];
  logic          pend_a, pend_b, waive_a, waive_b, hazard;

  assign src = src_regs(dec_ir_i);
  assign dst = dst_reg(dec_ir_i);

  assign pend_a = src.use_a & busy[src.addr_a];
  assign pend_b = src.use_b & busy[src.addr_b];

  // A single pending write still sitting in EX from an ALU/MOV can be bypassed.
  assign waive_a = FWD_EN & (cnt[src.addr_a] == CW'(1)) & ex_q.valid & ex_q.fwdable
                 & (ex_q.dst == src.addr_a);
  assign waive_b = FWD_EN & (cnt[src.addr_b] == CW'(1)) & ex_q.valid & ex_q.fwdable
                 & (ex_q.dst == src.addr_b);

  assign hazard   = dec_valid_i & ((pend_a & ~waive_a) | (pend_b & ~waive_b)
                                   | (dst.writes & full[dst.addr]));
  assign stall_o  = dec_valid_i & (hazard | ~ex_ready_i);
  assign issue_o  = dec_valid_i & ~stall_o;
  assign bubble_o = stall_o;
  assign fwd_a_o  = dec_valid_i & pend_a & waive_a;
  assign fwd_b_o  = dec_valid_i & pend_b & waive_b;

  for (genvar r = 0; r < 16; r++) begin : g_sb
    assign inc[r]    = issue_o & dst.writes & (dst.addr == 4'(r));
    assign dec_wb[r] = wb_en_i & (wb_addr_i == 4'(r));
    assign dec_sq[r] = squash_en_i & (squash_addr_i == 4'(r));

    scoreboard_entry #(
      .MAX_INFLIGHT (MAX_INFLIGHT),
      .CW           (CW)
    ) u_ent (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .inc_i    (inc[r]),
      .dec_wb_i (dec_wb[r]),
      .dec_sq_i (dec_sq[r]),
      .busy_o   (busy[r]),
      .full_o   (full[r]),
      .count_o  (cnt[r])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      ex_q <= '0;
    else if (issue_o)
      ex_q <= {1'b1, dst.addr, dst.writes & is_alu_or_mov(dec_ir_i)};
    else if (ex_ready_i | (squash_en_i & (squash_addr_i == ex_q.dst)))
      ex_q.valid <= 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      stall_cnt_o <= '0;
    else if (stall_o && (stall_cnt_o != 32'hFFFF_FFFF))
      stall_cnt_o <= stall_cnt_o + 32'd1;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: scoreboard stalls, full term, squash, ex_ready, reset mid-stall.
module tb_hazard_ctrl;
  import bexkat1Def::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        dec_valid_i;
  logic [31:0] dec_ir_i;
  logic        ex_ready_i;
  logic        wb_en_i;
  logic [3:0]  wb_addr_i;
  logic        squash_en_i;
  logic [3:0]  squash_addr_i;
  logic        issue_o, stall_o, bubble_o, fwd_a_o, fwd_b_o;
  logic [31:0] stall_cnt_o;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_cnt = 0;

  hazard_ctrl dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .dec_valid_i   (dec_valid_i),
    .dec_ir_i      (dec_ir_i),
    .ex_ready_i    (ex_ready_i),
    .wb_en_i       (wb_en_i),
    .wb_addr_i     (wb_addr_i),
    .squash_en_i   (squash_en_i),
    .squash_addr_i (squash_addr_i),
    .issue_o       (issue_o),
    .stall_o       (stall_o),
    .bubble_o      (bubble_o),
    .fwd_a_o       (fwd_a_o),
    .fwd_b_o       (fwd_b_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mk(input logic [3:0] t, input logic [3:0] op,
                                     input logic [3:0] ra, input logic [3:0] rb,
                                     input logic [3:0] rc);
    return {t, op, ra, rb, rc, 12'h000};
  endfunction

  task automatic tick;
    @(posedge clk_i);
    #2;
  endtask

  task automatic idle;
    dec_valid_i   = 1'b0;
    dec_ir_i      = '0;
    ex_ready_i    = 1'b1;
    wb_en_i       = 1'b0;
    wb_addr_i     = '0;
    squash_en_i   = 1'b0;
    squash_addr_i = '0;
  endtask

  task automatic wb(input logic [3:0] a);
    wb_en_i = 1'b1; wb_addr_i = a;
    tick();
    wb_en_i = 1'b0;
  endtask

  task automatic test_reset;
    idle();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", stall_o); end
    n_vec++; if (issue_o !== 1'b0) begin n_err++; $display("FAIL reset_issue got %b want 0", issue_o); end
    n_vec++; if ({fwd_a_o, fwd_b_o} !== 2'b00) begin n_err++; $display("FAIL reset_fwd got %b want 00", {fwd_a_o, fwd_b_o}); end
    n_vec++; if (stall_cnt_o !== 32'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", stall_cnt_o); end
    n_vec++; if (dut.g_sb[3].u_ent.count_o !== 2'd0) begin n_err++; $display("FAIL reset_count3 got %0d want 0", dut.g_sb[3].u_ent.count_o); end
  endtask

  task automatic test_issue;
    dec_valid_i = 1'b1; dec_ir_i = mk(T_ALU, 4'h0, 4'd3, 4'd1, 4'd2);
    #1;
    n_vec++; if (issue_o !== 1'b1) begin n_err++; $display("FAIL issue_alu got %b want 1", issue_o); end
    n_vec++; if (bubble_o !== 1'b0) begin n_err++; $display("FAIL issue_bubble got %b want 0", bubble_o); end
    tick();
    dec_valid_i = 1'b0;
    #1;
    n_vec++; if (dut.g_sb[3].u_ent.count_o !== 2'd1) begin n_err++; $display("FAIL issue_count3 got %0d want 1", dut.g_sb[3].u_ent.count_o); end
  endtask

  task automatic test_raw_stall;
    dec_valid_i = 1'b1; dec_ir_i = mk(T_ALU, 4'h0, 4'd4, 4'd3, 4'd0);
    #1;
    n_vec++; if ({stall_o, bubble_o, issue_o} !== 3'b110) begin n_err++; $display("FAIL raw_stall got %b want 110", {stall_o, bubble_o, issue_o}); end
    tick(); exp_cnt++;
    tick(); exp_cnt++;
    wb_en_i = 1'b1; wb_addr_i = 4'd3;
    #1;
    n_vec++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL raw_same_cycle_wb got %b want 1", stall_o); end
    tick(); exp_cnt++;
    wb_en_i = 1'b0;
    #1;
    n_vec++; if ({stall_o, issue_o} !== 2'b01) begin n_err++; $display("FAIL raw_release got %b want 01", {stall_o, issue_o}); end
    n_vec++; if (stall_cnt_o !== exp_cnt) begin n_err++; $display("FAIL raw_stall_cnt got %0d want %0d", stall_cnt_o, exp_cnt); end
    tick();
    dec_valid_i = 1'b0;
    wb(4'd4);
  endtask

  task automatic test_back_to_back;
    dec_valid_i = 1'b1; dec_ir_i = mk(T_LDI, 4'h0, 4'd5, 4'd0, 4'd0);
    tick();
    wb_en_i = 1'b1; wb_addr_i = 4'd5;
    #1;
    n_vec++; if (issue_o !== 1'b1) begin n_err++; $display("FAIL b2b_issue_with_wb got %b want 1", issue_o); end
    tick();
    wb_en_i = 1'b0;
    #1;
    n_vec++; if (dut.g_sb[5].u_ent.count_o !== 2'd1) begin n_err++; $display("FAIL b2b_net_hold got %0d want 1", dut.g_sb[5].u_ent.count_o); end
    tick();
    #1;
    n_vec++; if (issue_o !== 1'b1) begin n_err++; $display("FAIL b2b_third_issue got %b want 1", issue_o); end
    tick();
    #1;
    n_vec++; if (dut.g_sb[5].u_ent.count_o !== 2'd3) begin n_err++; $display("FAIL b2b_count_full got %0d want 3", dut.g_sb[5].u_ent.count_o); end
    n_vec++; if ({stall_o, issue_o} !== 2'b10) begin n_err++; $display("FAIL b2b_full_stall got %b want 10", {stall_o, issue_o}); end
    wb_en_i = 1'b1; wb_addr_i = 4'd5;
    tick(); exp_cnt++;
    wb_en_i = 1'b0;
    #1;
    n_vec++; if (issue_o !== 1'b1) begin n_err++; $display("FAIL b2b_after_wb got %b want 1", issue_o); end
    tick();
    dec_valid_i = 1'b0;
    repeat (3) wb(4'd5);
    #1;
    n_vec++; if (dut.g_sb[5].u_ent.count_o !== 2'd0) begin n_err++; $display("FAIL b2b_drained got %0d want 0", dut.g_sb[5].u_ent.count_o); end
  endtask

  task automatic test_squash;
    dec_valid_i = 1'b1; dec_ir_i = mk(T_ALU, 4'h0, 4'd7, 4'd0, 4'd0);
    tick();
    dec_ir_i = mk(T_CMP, 4'h0, 4'd7, 4'd1, 4'd0);
    squash_en_i = 1'b1; squash_addr_i = 4'd7;
    #1;
    n_vec++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL squash_same_cycle got %b want 1", stall_o); end
    tick(); exp_cnt++;
    squash_en_i = 1'b0;
    #1;
    n_vec++; if (dut.g_sb[7].u_ent.count_o !== 2'd0) begin n_err++; $display("FAIL squash_count7 got %0d want 0", dut.g_sb[7].u_ent.count_o); end
    n_vec++; if (issue_o !== 1'b1) begin n_err++; $display("FAIL squash_dep_issue got %b want 1", issue_o); end
    tick();
    dec_valid_i = 1'b0;
  endtask

  task automatic test_ex_ready;
    dec_valid_i = 1'b1; dec_ir_i = mk(T_LDI, 4'h0, 4'd8, 4'd0, 4'd0);
    ex_ready_i = 1'b0;
    #1;
    n_vec++; if ({stall_o, issue_o} !== 2'b10) begin n_err++; $display("FAIL exrdy_stall got %b want 10", {stall_o, issue_o}); end
    tick(); exp_cnt++;
    ex_ready_i = 1'b1;
    #1;
    n_vec++; if (issue_o !== 1'b1) begin n_err++; $display("FAIL exrdy_issue got %b want 1", issue_o); end
    tick();
    dec_valid_i = 1'b0;
    wb(4'd8);
  endtask

  task automatic test_mov_store;
    dec_valid_i = 1'b1; dec_ir_i = mk(T_MOV, 4'h0, 4'd9, 4'd1, 4'd2);
    tick();
    dec_valid_i = 1'b0;
    #1;
    n_vec++; if (dut.g_sb[9].u_ent.count_o !== 2'd0) begin n_err++; $display("FAIL mov_op0_nodst got %0d want 0", dut.g_sb[9].u_ent.count_o); end
    dec_valid_i = 1'b1; dec_ir_i = mk(T_MOV, 4'h1, 4'd9, 4'd1, 4'd2);
    tick();
    dec_valid_i = 1'b0;
    #1;
    n_vec++; if (dut.g_sb[9].u_ent.count_o !== 2'd1) begin n_err++; $display("FAIL mov_op1_dst got %0d want 1", dut.g_sb[9].u_ent.count_o); end
    dec_valid_i = 1'b1; dec_ir_i = mk(T_STORE, 4'h0, 4'd9, 4'd1, 4'd0);
    #1;
    n_vec++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL store_src_ra got %b want 1", stall_o); end
    tick(); exp_cnt++;
    dec_valid_i = 1'b0;
    wb(4'd9);
    #1;
    n_vec++; if (stall_cnt_o !== exp_cnt) begin n_err++; $display("FAIL mov_stall_cnt got %0d want %0d", stall_cnt_o, exp_cnt); end
  endtask

  task automatic test_forward;
    dec_valid_i = 1'b1; dec_ir_i = mk(T_ALU, 4'h0, 4'd2, 4'd0, 4'd0);
    tick();
    dec_ir_i = mk(T_ALU, 4'h0, 4'd6, 4'd2, 4'd0);
    #1;
`ifdef BEXKAT1_FORWARD_EN
    n_vec++; if ({stall_o, fwd_a_o, fwd_b_o} !== 3'b010) begin n_err++; $display("FAIL fwd_alu got %b want 010", {stall_o, fwd_a_o, fwd_b_o}); end
    tick();
    dec_valid_i = 1'b0;
    wb(4'd2);
    wb(4'd6);
    dec_valid_i = 1'b1; dec_ir_i = mk(T_LOAD, 4'h0, 4'd2, 4'd0, 4'd0);
    tick();
    dec_ir_i = mk(T_ALU, 4'h0, 4'd6, 4'd2, 4'd0);
    #1;
    n_vec++; if ({stall_o, fwd_a_o} !== 2'b10) begin n_err++; $display("FAIL fwd_load_stall got %b want 10", {stall_o, fwd_a_o}); end
    tick(); exp_cnt++;
    dec_valid_i = 1'b0;
    wb(4'd2);
`else
    n_vec++; if ({stall_o, fwd_a_o, fwd_b_o} !== 3'b100) begin n_err++; $display("FAIL nofwd_stall got %b want 100", {stall_o, fwd_a_o, fwd_b_o}); end
    tick(); exp_cnt++;
    dec_valid_i = 1'b0;
    wb(4'd2);
`endif
    #1;
    n_vec++; if (stall_cnt_o !== exp_cnt) begin n_err++; $display("FAIL fwd_stall_cnt got %0d want %0d", stall_cnt_o, exp_cnt); end
  endtask

  task automatic test_reset_mid_stall;
    dec_valid_i = 1'b1; dec_ir_i = mk(T_ALU, 4'h0, 4'd3, 4'd0, 4'd0);
    tick();
    dec_ir_i = mk(T_ALU, 4'h0, 4'd4, 4'd3, 4'd0);
    #1;
    n_vec++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL rst_mid_pre got %b want 1", stall_o); end
    tick(); exp_cnt++;
    #1 rst_i = 1'b1;
    #1;
    n_vec++; if ({stall_o, issue_o} !== 2'b01) begin n_err++; $display("FAIL rst_mid_stall got %b want 01", {stall_o, issue_o}); end
    n_vec++; if (dut.g_sb[3].u_ent.count_o !== 2'd0) begin n_err++; $display("FAIL rst_mid_count3 got %0d want 0", dut.g_sb[3].u_ent.count_o); end
    n_vec++; if (stall_cnt_o !== 32'd0) begin n_err++; $display("FAIL rst_mid_cnt got %0d want 0", stall_cnt_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    exp_cnt = 0;
    tick();
    dec_valid_i = 1'b0;
    #1;
    n_vec++; if (dut.g_sb[4].u_ent.count_o !== 2'd1) begin n_err++; $display("FAIL rst_next_issue got %0d want 1", dut.g_sb[4].u_ent.count_o); end
    n_vec++; if (stall_cnt_o !== exp_cnt) begin n_err++; $display("FAIL rst_post_cnt got %0d want %0d", stall_cnt_o, exp_cnt); end
  endtask

  initial begin
    test_reset();
    test_issue();
    test_raw_stall();
    test_back_to_back();
    test_squash();
    test_ex_ready();
    test_mov_store();
    test_forward();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
